// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a length-prefixed program image as a byte stream,
// assembles little-endian 32-bit words into instruction memory, checks an XOR
// checksum and releases the core from reset only when the image is verified.
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    input  logic                  load_req,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        ST_LEN0 = 3'd0,
        ST_LEN1 = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_RUN  = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // Word index is one bit wider than the address so a full memory image fits.
    localparam int              CNT_W    = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [16:0]      CAPACITY = 17'd1 << ADDR_WIDTH;

    // Running checksum step: XOR-accumulate one data byte.
    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data_byte);
        return acc ^ data_byte;
    endfunction

    state_t                  state_r;
    state_t                  state_nxt_s;

    logic [7:0]              len_lo_r;
    logic [15:0]             len_r;
    logic [CNT_W-1:0]        word_cnt_r;
    logic [CNT_W-1:0]        word_cnt_inc_s;
    logic [1:0]              byte_cnt_r;
    logic [23:0]             word_buf_r;
    logic [7:0]              csum_r;

    logic                    imem_we_r;
    logic [ADDR_WIDTH-1:0]   imem_addr_r;
    logic [31:0]             imem_wdata_r;

    logic                    rx_ready_s;
    logic                    accept_s;
    logic                    restart_s;
    logic                    oversize_s;
    logic                    len_zero_s;
    logic                    last_word_s;
    logic                    csum_ok_s;

    // Handshake, restart and length/checksum decodes from registered state.
    always_comb begin
        rx_ready_s     = 1'b0;
        restart_s      = 1'b0;
        word_cnt_inc_s = word_cnt_r + CNT_ONE;
        case (state_r)
            ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM: rx_ready_s = 1'b1;
            ST_RUN, ST_ERR:                     restart_s  = load_req;
            default: begin
                rx_ready_s = 1'b0;
                restart_s  = 1'b0;
            end
        endcase
        accept_s    = rx_valid & rx_ready_s;
        oversize_s  = {1'b0, rx_data, len_lo_r} > CAPACITY;
        len_zero_s  = ({rx_data, len_lo_r} == 16'd0);
        last_word_s = (17'(word_cnt_inc_s) == {1'b0, len_r});
        csum_ok_s   = (rx_data == csum_r);
    end

    // Next-state logic of the load sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_LEN0: begin
                if (accept_s) begin
                    state_nxt_s = ST_LEN1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_LEN1: begin
                if (accept_s) begin
                    if (oversize_s) begin
                        state_nxt_s = ST_ERR;
                    end else if (len_zero_s) begin
                        state_nxt_s = ST_CSUM;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_DATA: begin
                if (accept_s && (byte_cnt_r == 2'd3) && last_word_s) begin
                    state_nxt_s = ST_CSUM;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_CSUM: begin
                if (accept_s) begin
                    state_nxt_s = csum_ok_s ? ST_RUN : ST_ERR;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN, ST_ERR: begin
                if (restart_s) begin
                    state_nxt_s = ST_LEN0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = ST_LEN0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_LEN0;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: length capture, word assembly, checksum and memory write strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_lo_r     <= 8'd0;
            len_r        <= 16'd0;
            word_cnt_r   <= '0;
            byte_cnt_r   <= 2'd0;
            word_buf_r   <= 24'd0;
            csum_r       <= 8'd0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= '0;
            imem_wdata_r <= 32'd0;
        end else begin
            imem_we_r <= 1'b0;
            if (restart_s) begin
                // Address/data keep the last write; only the load context is cleared.
                len_lo_r   <= 8'd0;
                len_r      <= 16'd0;
                word_cnt_r <= '0;
                byte_cnt_r <= 2'd0;
                word_buf_r <= 24'd0;
                csum_r     <= 8'd0;
            end else if (accept_s) begin
                case (state_r)
                    ST_LEN0: len_lo_r <= rx_data;
                    ST_LEN1: len_r    <= {rx_data, len_lo_r};
                    ST_DATA: begin
                        csum_r     <= csum_update(csum_r, rx_data);
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        case (byte_cnt_r)
                            2'd0: word_buf_r[7:0]   <= rx_data;
                            2'd1: word_buf_r[15:8]  <= rx_data;
                            2'd2: word_buf_r[23:16] <= rx_data;
                            2'd3: begin
                                imem_we_r    <= 1'b1;
                                imem_addr_r  <= word_cnt_r[ADDR_WIDTH-1:0];
                                imem_wdata_r <= {rx_data, word_buf_r};
                                word_cnt_r   <= word_cnt_inc_s;
                            end
                            default: word_buf_r <= word_buf_r;
                        endcase
                    end
                    default: csum_r <= csum_r;
                endcase
            end else begin
                csum_r <= csum_r;
            end
        end
    end

    assign rx_ready     = rx_ready_s;
    assign busy         = rx_ready_s;
    assign done         = (state_r == ST_RUN);
    assign core_reset_n = (state_r == ST_RUN);
    assign error        = (state_r == ST_ERR);
    assign imem_we      = imem_we_r;
    assign imem_addr    = imem_addr_r;
    assign imem_wdata   = imem_wdata_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed testbench for imem_boot_loader (ADDR_WIDTH = 10).
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        load_req;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset_n;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    // Write log filled by the monitor below.
    int          wr_n = 0;
    int          long_pulse = 0;
    logic        we_prev = 1'b0;
    logic [9:0]  wr_addr [0:2047];
    logic [31:0] wr_data [0:2047];

    imem_boot_loader #(.ADDR_WIDTH(10)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .load_req     (load_req),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset_n (core_reset_n),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    // Record every memory write and flag strobes longer than one cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_n < 2048) begin
                wr_addr[wr_n] <= imem_addr;
                wr_data[wr_n] <= imem_wdata;
            end
            wr_n <= wr_n + 1;
        end
        if (imem_we === 1'b1 && we_prev === 1'b1) long_pulse <= long_pulse + 1;
        we_prev <= imem_we;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        waited   = 0;
        while (rx_ready !== 1'b1 && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        n_checks++;
        if (waited >= 50) begin
            n_fail++;
            $display("FAIL send_byte_timeout: byte %h not accepted, rx_ready=%b required 1", b, rx_ready);
        end else begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Two-word image 0x00000013, 0x00100093 with the given checksum byte.
    task automatic send_image(input int gap_max, input logic [7:0] csum);
        logic [7:0] img [0:9];
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < 10; i++) send_byte(img[i], $urandom_range(0, gap_max));
        send_byte(csum, $urandom_range(0, gap_max));
    endtask

    task automatic check_two_writes(input string tag, input int base);
        n_checks++;
        if (wr_n - base !== 2) begin
            n_fail++; $display("FAIL %s_wr_count: got %0d required 2", tag, wr_n - base);
        end
        n_checks++;
        if (wr_addr[base] !== 10'd0 || wr_data[base] !== 32'h00000013) begin
            n_fail++; $display("FAIL %s_word0: got %h/%h required 000/00000013", tag, wr_addr[base], wr_data[base]);
        end
        n_checks++;
        if (wr_addr[base+1] !== 10'd1 || wr_data[base+1] !== 32'h00100093) begin
            n_fail++; $display("FAIL %s_word1: got %h/%h required 001/00100093", tag, wr_addr[base+1], wr_data[base+1]);
        end
    endtask

    task automatic do_restart();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        n_checks++;
        if ({busy, rx_ready, core_reset_n, done, error} !== 5'b11000) begin
            n_fail++;
            $display("FAIL restart: busy,rdy,crst,done,err=%b required 11000", {busy, rx_ready, core_reset_n, done, error});
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({rx_ready, busy, imem_we, core_reset_n, done, error} !== 6'b110000 ||
            imem_addr !== 10'd0 || imem_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_values: rdy,busy,we,crst,done,err=%b addr=%h wdata=%h required 110000/000/00000000",
                     {rx_ready, busy, imem_we, core_reset_n, done, error}, imem_addr, imem_wdata);
        end
        @(posedge clk);
        #3 reset_n = 1'b1;
        wait_cycles(2);
        n_checks++;
        if ({rx_ready, busy, core_reset_n} !== 3'b110) begin
            n_fail++; $display("FAIL reset_release: rdy,busy,crst=%b required 110", {rx_ready, busy, core_reset_n});
        end
    endtask

    task automatic test_empty();
        int base = wr_n;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        n_checks++;
        if ({done, core_reset_n, rx_ready, busy, error} !== 5'b11000) begin
            n_fail++; $display("FAIL empty_release: done,crst,rdy,busy,err=%b required 11000", {done, core_reset_n, rx_ready, busy, error});
        end
        wait_cycles(2);
        n_checks++;
        if (wr_n !== base) begin
            n_fail++; $display("FAIL empty_no_write: got %0d writes required 0", wr_n - base);
        end
    endtask

    task automatic test_two_word();
        int base;
        do_restart();
        base = wr_n;
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        n_checks++;
        if (imem_we !== 1'b1 || imem_addr !== 10'd0 || imem_wdata !== 32'h00000013) begin
            n_fail++; $display("FAIL two_word_w0: we=%b addr=%h wdata=%h required 1/000/00000013", imem_we, imem_addr, imem_wdata);
        end
        send_byte(8'h93, 0);
        n_checks++;
        if (imem_we !== 1'b0 || imem_addr !== 10'd0 || imem_wdata !== 32'h00000013) begin
            n_fail++; $display("FAIL two_word_pulse_end: we=%b addr=%h wdata=%h required 0/000/00000013", imem_we, imem_addr, imem_wdata);
        end
        send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
        n_checks++;
        if (imem_we !== 1'b1 || imem_addr !== 10'd1 || imem_wdata !== 32'h00100093) begin
            n_fail++; $display("FAIL two_word_w1: we=%b addr=%h wdata=%h required 1/001/00100093", imem_we, imem_addr, imem_wdata);
        end
        n_checks++;
        if (core_reset_n !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL two_word_early_release: crst=%b done=%b required 0/0", core_reset_n, done);
        end
        send_byte(8'h90, 0);
        n_checks++;
        if ({done, core_reset_n, rx_ready, busy, error, imem_we} !== 6'b110000) begin
            n_fail++; $display("FAIL two_word_release: done,crst,rdy,busy,err,we=%b required 110000", {done, core_reset_n, rx_ready, busy, error, imem_we});
        end
        wait_cycles(2);
        check_two_writes("two_word", base);
        n_checks++;
        if (long_pulse !== 0) begin
            n_fail++; $display("FAIL two_word_pulse_width: got %0d long pulses required 0", long_pulse);
        end
    endtask

    task automatic test_bad_csum();
        int base;
        do_restart();
        base = wr_n;
        send_image(0, 8'h91);
        n_checks++;
        if ({error, done, core_reset_n, rx_ready, busy} !== 5'b10000) begin
            n_fail++; $display("FAIL bad_csum_err: err,done,crst,rdy,busy=%b required 10000", {error, done, core_reset_n, rx_ready, busy});
        end
        wait_cycles(3);
        n_checks++;
        if (core_reset_n !== 1'b0 || error !== 1'b1) begin
            n_fail++; $display("FAIL bad_csum_hold: crst=%b err=%b required 0/1", core_reset_n, error);
        end
        check_two_writes("bad_csum", base);
        do_restart();
        base = wr_n;
        send_image(0, 8'h90);
        n_checks++;
        if (done !== 1'b1 || core_reset_n !== 1'b1) begin
            n_fail++; $display("FAIL bad_csum_reload: done=%b crst=%b required 1/1", done, core_reset_n);
        end
        wait_cycles(2);
        check_two_writes("reload", base);
    endtask

    task automatic test_oversize();
        int base;
        logic [31:0] word;
        logic [7:0]  csum;
        do_restart();
        base = wr_n;
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        n_checks++;
        if ({error, rx_ready, busy, core_reset_n} !== 4'b1000) begin
            n_fail++; $display("FAIL oversize_err: err,rdy,busy,crst=%b required 1000", {error, rx_ready, busy, core_reset_n});
        end
        wait_cycles(2);
        n_checks++;
        if (wr_n !== base) begin
            n_fail++; $display("FAIL oversize_no_write: got %0d writes required 0", wr_n - base);
        end
        do_restart();
        base = wr_n;
        csum = 8'h00;
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        for (int w = 0; w < 1024; w++) begin
            word = 32'hC0DE0000 | 32'(w);
            for (int k = 0; k < 4; k++) begin
                csum = csum ^ word[8*k +: 8];
                send_byte(word[8*k +: 8], 0);
            end
        end
        send_byte(csum, 0);
        n_checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            n_fail++; $display("FAIL full_image_done: done=%b err=%b required 1/0", done, error);
        end
        wait_cycles(2);
        n_checks++;
        if (wr_n - base !== 1024) begin
            n_fail++; $display("FAIL full_image_count: got %0d required 1024", wr_n - base);
        end
        n_checks++;
        if (wr_addr[base] !== 10'd0 || wr_data[base] !== 32'hC0DE0000) begin
            n_fail++; $display("FAIL full_image_first: got %h/%h required 000/c0de0000", wr_addr[base], wr_data[base]);
        end
        n_checks++;
        if (wr_addr[base+1023] !== 10'd1023 || wr_data[base+1023] !== 32'hC0DE03FF) begin
            n_fail++; $display("FAIL full_image_last: got %h/%h required 3ff/c0de03ff", wr_addr[base+1023], wr_data[base+1023]);
        end
    endtask

    task automatic test_flow_control();
        int base;
        do_restart();
        base = wr_n;
        send_image(3, 8'h90);
        n_checks++;
        if (done !== 1'b1 || core_reset_n !== 1'b1) begin
            n_fail++; $display("FAIL flow_done: done=%b crst=%b required 1/1", done, core_reset_n);
        end
        wait_cycles(2);
        check_two_writes("flow", base);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        wait_cycles(5);
        n_checks++;
        if ({rx_ready, done, core_reset_n, busy} !== 4'b0110 || wr_n - base !== 2) begin
            n_fail++; $display("FAIL flow_run_hold: rdy,done,crst,busy=%b writes=%0d required 0110/2", {rx_ready, done, core_reset_n, busy}, wr_n - base);
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        int base;
        logic [7:0] part [0:6];
        do_restart();
        base = wr_n;
        part = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93};
        for (int i = 0; i < 7; i++) send_byte(part[i], 0);
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({rx_ready, busy, imem_we, core_reset_n, done, error} !== 6'b110000 ||
            imem_addr !== 10'd0 || imem_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset_values: rdy,busy,we,crst,done,err=%b addr=%h wdata=%h required 110000/000/00000000",
                     {rx_ready, busy, imem_we, core_reset_n, done, error}, imem_addr, imem_wdata);
        end
        wait_cycles(3);
        @(posedge clk);
        #3 reset_n = 1'b1;
        wait_cycles(1);
        n_checks++;
        if (wr_n - base !== 1) begin
            n_fail++; $display("FAIL mid_reset_partial: got %0d writes required 1", wr_n - base);
        end
        base = wr_n;
        send_image(0, 8'h90);
        n_checks++;
        if (done !== 1'b1 || core_reset_n !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_reload: done=%b crst=%b required 1/1", done, core_reset_n);
        end
        wait_cycles(2);
        check_two_writes("mid_reset", base);
    endtask

    initial begin
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        load_req = 1'b0;
        wait_cycles(3);
        test_reset();
        test_empty();
        test_two_word();
        test_bad_csum();
        test_oversize();
        test_flow_control();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot sequencer for the single-cycle RISC-V core. It receives a program image as a byte stream (valid/ready), assembles little-endian 32-bit words and writes them into the instruction memory's write port. It verifies an XOR checksum, and only then releases the core from reset. It sits between the external byte source (UART receiver or test harness) and the core's `reset_n` input and instruction-memory `we/addr/write_data` ports.

## Interface
- `ADDR_WIDTH`, default 10: instruction-memory word-address width; capacity = 2^ADDR_WIDTH words.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: byte available.
- `rx_data` in 8: byte value.
- `rx_ready` out 1: loader accepts a byte; a transfer occurs on a rising edge with `rx_valid & rx_ready`.
- `load_req` in 1: restart loading; honoured only in RUN or ERR.
- `imem_we` out 1: instruction-memory write strobe.
- `imem_addr` out ADDR_WIDTH: word address.
- `imem_wdata` out 32: word to write.
- `core_reset_n` out 1: active-low reset to the core; 0 while the image is not verified.
- `busy` out 1: loading in progress.
- `done` out 1: image verified, core running.
- `error` out 1: load failed; core held in reset.

## Operation
- Stream format:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - 4·N data bytes, little-endian per word.
  - CSUM: one byte equal to the XOR of all data bytes. Length bytes are excluded.
- States:
  - LEN0: accept LEN_LO → LEN1.
  - LEN1: accept LEN_HI.
    - N > 2^ADDR_WIDTH → ERR.
    - N == 0 → CSUM.
    - Otherwise → DATA.
  - DATA: accept bytes.
    - 2-bit byte counter; byte k goes to `word[8k+7:8k]`.
    - The running checksum XORs every data byte.
    - On the 4th byte, issue a write at word index w (0-based), then w+1.
    - After word N−1 is accepted → CSUM.
  - CSUM: accept one byte. Equal to the running checksum → RUN, else → ERR.
  - RUN: `core_reset_n`=1, `done`=1.
  - ERR: `error`=1, `core_reset_n`=0.
- `load_req`=1 in RUN or ERR → LEN0. This clears the counters, the checksum and `done`/`error`, and drives `core_reset_n` to 0. `load_req` is ignored in all other states.
- `rx_ready`=1 exactly in LEN0, LEN1, DATA, CSUM; 0 in RUN and ERR. Bytes presented in RUN/ERR are not consumed.
- `busy`=1 exactly in LEN0, LEN1, DATA, CSUM.
- Word index counter is ADDR_WIDTH+1 bits so N = 2^ADDR_WIDTH fits. `imem_addr` = index[ADDR_WIDTH-1:0]; never wraps for legal N.
- Memory locations beyond N−1 are never written; earlier contents persist.

## Timing
- Reset values, asserted asynchronously:
  - state=LEN0
  - `rx_ready`=1, `busy`=1
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0
  - `core_reset_n`=0, `done`=0, `error`=0
  - internal counters and checksum = 0
- All outputs are registered or decoded from registered state only. No combinational path from `rx_valid`/`rx_data` to any output.
- Write latency: `imem_we` is high for exactly one cycle, the cycle after the edge that accepts a word's 4th byte. `imem_addr`/`imem_wdata` are valid in that cycle and hold until the next write.
- Back-to-back bytes are accepted at one per cycle. A write pulse and the next byte acceptance may coincide.
- Release: `core_reset_n`, `done` rise the cycle after a matching CSUM handshake, at least 1 cycle after the last `imem_we`.
- ERR entry: on the edge accepting LEN_HI (oversize) or CSUM (mismatch). `rx_ready`=0 the following cycle.
- `load_req` in RUN/ERR: `core_reset_n`=0, `rx_ready`=1, `busy`=1 the next cycle.
- Reset mid-load discards any partial word; no `imem_we` for it.
- Idle cycles (`rx_valid`=0) anywhere in the stream are allowed; there is no timeout.

## Test plan
- **Empty image:** reset, send 00 00, CSUM 00 → no `imem_we`; `done`=1, `core_reset_n`=1, `rx_ready`=0 the cycle after CSUM.
- **Two-word image:** send 02 00, 13 00 00 00, 93 00 10 00, CSUM 90.
  - Writes: addr 0 = 0x00000013, addr 1 = 0x00100093, each a 1-cycle pulse following its 4th byte.
  - Then `done`=1.
- **Bad checksum:** same image with CSUM 91 → both words written, `error`=1, `core_reset_n` stays 0. Then pulse `load_req` → LEN0, `busy`=1, `error`=0; a correct reload reaches RUN.
- **Oversize:** ADDR_WIDTH=10, send 01 04 (N=1025) → `error`=1 after 2nd byte, no writes. Send 00 04 (N=1024) plus data → last write at addr 1023.
- **Flow control:** random `rx_valid` gaps during the two-word image → identical writes and release. `rx_valid` held high in RUN → `rx_ready`=0, no state change.
- **Reset mid-load:** assert `reset_n` after 5 data bytes → all outputs at reset values immediately, no write of the partial word. A fresh two-word load succeeds.
